// File: rtl/ibex_pkg.sv
// ============================================================================
// Module      : ibex_pkg
// Description : Shared types and constants for the multdiv issuer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_pkg;

    // Operator encoding understood by the multiply/divide unit
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    // Issuer sequencing states
    typedef enum logic [1:0] {
        MDI_IDLE = 2'b00,
        MDI_BUSY = 2'b01,
        MDI_RESP = 2'b10
    } multdiv_issue_state_e;

    // Expected latencies in data-independent-timing mode, and abort limit
    localparam int unsigned MDI_MUL_CYCLES     = 34;
    localparam int unsigned MDI_DIV_CYCLES     = 37;
    localparam int unsigned MDI_TIMEOUT_CYCLES = 48;

    // True for operators executed by the multiplier datapath
    function automatic logic md_op_is_mul(md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_multdiv_lat_counter.sv
// ============================================================================
// Module      : ibex_multdiv_lat_counter
// Description : Saturating latency counter with clear/enable and a timeout
//               compare. cnt_o already includes the current enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_multdiv_lat_counter #(
    parameter int unsigned CntW          = 6,
    parameter int unsigned TimeoutCycles = 48
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [CntW-1:0] cnt_o,
    output logic            timeout_o
);

    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic [CntW-1:0] w_cnt_inc;

    // Saturating increment; clear wins over enable
    always_comb begin
        w_cnt_inc = (cnt_q == CntMax) ? cnt_q : (cnt_q + CntOne);
        cnt_d     = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = w_cnt_inc;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The value reported for a cycle counts that cycle itself
    assign cnt_o     = w_cnt_inc;
    assign timeout_o = en_i && (32'(w_cnt_inc) >= TimeoutCycles);

endmodule

`default_nettype wire

// File: rtl/ibex_multdiv_issuer.sv
// ============================================================================
// Module      : ibex_multdiv_issuer
// Description : Initiator-side sequencer for the multiply/divide unit. Issues
//               one operation per request, holds it until valid, buffers the
//               result and measured latency for a response handshake.
//               Optional macro IBEX_MULTDIV_DIT_CHECK_EN enables the
//               data-independent-timing latency check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_multdiv_issuer
    import ibex_pkg::*;
#(
    parameter int unsigned CntW          = 6,
    parameter int unsigned TimeoutCycles = MDI_TIMEOUT_CYCLES,
    parameter int unsigned MulCycles     = MDI_MUL_CYCLES,
    parameter int unsigned DivCycles     = MDI_DIV_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  md_op_e          req_op_i,
    input  logic [1:0]      req_signed_mode_i,
    input  logic [31:0]     req_op_a_i,
    input  logic [31:0]     req_op_b_i,
    input  logic            data_ind_timing_i,
    output logic            mult_en_o,
    output logic            div_en_o,
    output logic            mult_sel_o,
    output logic            div_sel_o,
    output md_op_e          operator_o,
    output logic [1:0]      signed_mode_o,
    output logic [31:0]     op_a_o,
    output logic [31:0]     op_b_o,
    output logic            data_ind_timing_o,
    output logic            multdiv_ready_id_o,
    input  logic            valid_i,
    input  logic [31:0]     result_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_result_o,
    output logic [CntW-1:0] rsp_cycles_o,
    output logic            rsp_err_o,
    output logic            busy_o
);

    localparam logic [1:0] StIdle = MDI_IDLE;
    localparam logic [1:0] StBusy = MDI_BUSY;
    localparam logic [1:0] StResp = MDI_RESP;

    logic [1:0]      state_q, state_d;
    md_op_e          operator_q, operator_d;
    logic [1:0]      signed_mode_q, signed_mode_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic            dit_q, dit_d;
    logic            mult_en_q, mult_en_d;
    logic            div_en_q, div_en_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [CntW-1:0] rsp_cycles_q, rsp_cycles_d;
    logic            rsp_err_q, rsp_err_d;

    logic            w_accept;
    logic            w_ready_id;
    logic [CntW-1:0] w_cnt;
    logic            w_timeout;
    logic [CntW-1:0] w_exp_cycles;
    logic            w_dit_mismatch;

    assign w_accept = (state_q == StIdle) && req_valid_i;

    ibex_multdiv_lat_counter #(
        .CntW          (CntW),
        .TimeoutCycles (TimeoutCycles)
    ) u_lat_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (w_accept),
        .en_i      (state_q == StBusy),
        .cnt_o     (w_cnt),
        .timeout_o (w_timeout)
    );

    assign w_exp_cycles = md_op_is_mul(operator_q) ? CntW'(MulCycles) : CntW'(DivCycles);

`ifdef IBEX_MULTDIV_DIT_CHECK_EN
    assign w_dit_mismatch = dit_q && (w_cnt != w_exp_cycles);

    dit_latency_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((state_q == StBusy) && valid_i && dit_q) |-> (w_cnt == w_exp_cycles));
`else
    logic w_unused_exp_cycles;
    assign w_unused_exp_cycles = ^w_exp_cycles;
    assign w_dit_mismatch      = 1'b0;
`endif

    // Next-state, operand latch and response capture
    always_comb begin
        state_d       = state_q;
        operator_d    = operator_q;
        signed_mode_d = signed_mode_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        dit_d         = dit_q;
        mult_en_d     = mult_en_q;
        div_en_d      = div_en_q;
        rsp_result_d  = rsp_result_q;
        rsp_cycles_d  = rsp_cycles_q;
        rsp_err_d     = rsp_err_q;
        w_ready_id    = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    operator_d    = req_op_i;
                    signed_mode_d = req_signed_mode_i;
                    op_a_d        = req_op_a_i;
                    op_b_d        = req_op_b_i;
                    dit_d         = data_ind_timing_i;
                    mult_en_d     = md_op_is_mul(req_op_i);
                    div_en_d      = !md_op_is_mul(req_op_i);
                    state_d       = StBusy;
                end
            end
            StBusy: begin
                // A result arriving on the timeout cycle still counts as a result
                if (valid_i) begin
                    w_ready_id   = 1'b1;
                    rsp_result_d = result_i;
                    rsp_cycles_d = w_cnt;
                    rsp_err_d    = w_dit_mismatch;
                    mult_en_d    = 1'b0;
                    div_en_d     = 1'b0;
                    state_d      = StResp;
                end else if (w_timeout) begin
                    // Ready pulse releases a unit that will never answer
                    w_ready_id   = 1'b1;
                    rsp_result_d = '0;
                    rsp_cycles_d = w_cnt;
                    rsp_err_d    = 1'b1;
                    mult_en_d    = 1'b0;
                    div_en_d     = 1'b0;
                    state_d      = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            operator_q    <= MD_OP_MULL;
            signed_mode_q <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            dit_q         <= 1'b0;
            mult_en_q     <= 1'b0;
            div_en_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_cycles_q  <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            operator_q    <= operator_d;
            signed_mode_q <= signed_mode_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            dit_q         <= dit_d;
            mult_en_q     <= mult_en_d;
            div_en_q      <= div_en_d;
            rsp_result_q  <= rsp_result_d;
            rsp_cycles_q  <= rsp_cycles_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Ready is masked by reset so every output reads 0 while reset is held
    assign req_ready_o        = (state_q == StIdle) && rst_ni;
    assign mult_en_o          = mult_en_q;
    assign div_en_o           = div_en_q;
    assign mult_sel_o         = mult_en_q;
    assign div_sel_o          = div_en_q;
    assign operator_o         = operator_q;
    assign signed_mode_o      = signed_mode_q;
    assign op_a_o             = op_a_q;
    assign op_b_o             = op_b_q;
    assign data_ind_timing_o  = dit_q;
    assign multdiv_ready_id_o = w_ready_id;
    assign rsp_valid_o        = (state_q == StResp);
    assign rsp_result_o       = rsp_result_q;
    assign rsp_cycles_o       = rsp_cycles_q;
    assign rsp_err_o          = rsp_err_q;
    assign busy_o             = (state_q != StIdle);

endmodule

`default_nettype wire

// File: tb/tb_ibex_multdiv_issuer.sv
// ============================================================================
// Module      : tb_ibex_multdiv_issuer
// Description : Self-checking bench for ibex_multdiv_issuer with a stub
//               multdiv unit and a behavioural RISC-V M-extension model.
//               Honours IBEX_MULTDIV_DIT_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ibex_multdiv_issuer;
    import ibex_pkg::*;

    localparam int CNTW = 6;
    localparam int TO   = 48;
    localparam int MULC = 34;
    localparam int DIVC = 37;
`ifdef IBEX_MULTDIV_DIT_CHECK_EN
    localparam bit DIT_EN = 1'b1;
`else
    localparam bit DIT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready_o;
    md_op_e          req_op;
    logic [1:0]      req_sm;
    logic [31:0]     req_a, req_b;
    logic            dit_i;
    logic            mult_en_o, div_en_o, mult_sel_o, div_sel_o;
    md_op_e          operator_o;
    logic [1:0]      signed_mode_o;
    logic [31:0]     op_a_o, op_b_o;
    logic            data_ind_timing_o, multdiv_ready_id_o;
    logic            valid_i;
    logic [31:0]     result_i;
    logic            rsp_valid_o, rsp_ready;
    logic [31:0]     rsp_result_o;
    logic [CNTW-1:0] rsp_cycles_o;
    logic            rsp_err_o, busy_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ibex_multdiv_issuer #(
        .CntW(CNTW), .TimeoutCycles(TO), .MulCycles(MULC), .DivCycles(DIVC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_op_i(req_op),
        .req_signed_mode_i(req_sm), .req_op_a_i(req_a), .req_op_b_i(req_b),
        .data_ind_timing_i(dit_i),
        .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
        .operator_o(operator_o), .signed_mode_o(signed_mode_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
        .data_ind_timing_o(data_ind_timing_o), .multdiv_ready_id_o(multdiv_ready_id_o),
        .valid_i(valid_i), .result_i(result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result_o),
        .rsp_cycles_o(rsp_cycles_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    // RISC-V M-extension arithmetic; signed_mode = {b_signed, a_signed}
    function automatic logic [31:0] ref_result(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        sgn;
        ea  = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
        eb  = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
        p   = ea * eb;
        sgn = sm[0] & sm[1];
        case (op)
            MD_OP_MULL: return p[31:0];
            MD_OP_MULH: return p[63:32];
            MD_OP_DIV: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                if (sgn) return $signed(a) / $signed(b);
                return a / b;
            end
            default: begin
                if (b == 32'h0) return a;
                if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                if (sgn) return $signed(a) % $signed(b);
                return a % b;
            end
        endcase
    endfunction

    // One full transaction. Caller is at a negedge with the DUT idle.
    // lat = cycle on which the stub unit answers (0 = never answers).
    task automatic do_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic dit, input int lat,
                         input int hold, input string name);
        bit          is_mul, to, exp_err, done;
        int          exp_cyc;
        logic [31:0] exp_res;
        is_mul  = (op == MD_OP_MULL) || (op == MD_OP_MULH);
        to      = (lat < 1) || (lat > TO);
        exp_cyc = to ? TO : lat;
        exp_res = to ? 32'h0 : ref_result(op, sm, a, b);
        exp_err = to || (DIT_EN && dit && exp_cyc != (is_mul ? MULC : DIVC));

        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready_o);
        end
        req_valid = 1'b1; req_op = op; req_sm = sm; req_a = a; req_b = b; dit_i = dit;
        @(negedge clk);
        // Junk on the request side must be ignored while busy
        req_valid = 1'b1; req_op = md_op_e'($urandom_range(0, 3));
        req_sm = 2'($urandom); req_a = $urandom; req_b = $urandom; dit_i = 1'($urandom);

        done = 1'b0;
        for (int k = 1; k <= TO + 2 && !done; k++) begin
            if (k > 1) @(negedge clk);
            vectors++;
            if ({busy_o, req_ready_o, rsp_valid_o} !== 3'b100) begin
                miscompares++;
                $display("FAIL %s busy_status c%0d: got %b want 100", name, k, {busy_o, req_ready_o, rsp_valid_o});
            end
            vectors++;
            if ({mult_en_o, div_en_o, mult_sel_o, div_sel_o} !== {is_mul, !is_mul, is_mul, !is_mul}) begin
                miscompares++;
                $display("FAIL %s busy_enables c%0d: got %b want %b", name, k,
                         {mult_en_o, div_en_o, mult_sel_o, div_sel_o}, {is_mul, !is_mul, is_mul, !is_mul});
            end
            vectors++;
            if ({operator_o, signed_mode_o, op_a_o, op_b_o, data_ind_timing_o} !== {op, sm, a, b, dit}) begin
                miscompares++;
                $display("FAIL %s busy_operands c%0d: got %h want %h", name, k,
                         {operator_o, signed_mode_o, op_a_o, op_b_o, data_ind_timing_o}, {op, sm, a, b, dit});
            end
            // Stub unit: computes from what the issuer drives
            valid_i  = (k == lat);
            result_i = ref_result(operator_o, signed_mode_o, op_a_o, op_b_o);
            #1;
            vectors++;
            if (multdiv_ready_id_o !== (k == exp_cyc)) begin
                miscompares++;
                $display("FAIL %s ready_id c%0d: got %b want %b", name, k, multdiv_ready_id_o, (k == exp_cyc));
            end
            if (k == exp_cyc) done = 1'b1;
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            rsp_ready = (h == hold);
            valid_i   = 1'($urandom);
            result_i  = $urandom;
            #1;
            vectors++;
            if ({busy_o, req_ready_o, rsp_valid_o, mult_en_o, div_en_o, multdiv_ready_id_o} !== 6'b101000) begin
                miscompares++;
                $display("FAIL %s resp_status h%0d: got %b want 101000", name, h,
                         {busy_o, req_ready_o, rsp_valid_o, mult_en_o, div_en_o, multdiv_ready_id_o});
            end
            vectors++;
            if ({rsp_result_o, rsp_cycles_o, rsp_err_o} !== {exp_res, CNTW'(exp_cyc), exp_err}) begin
                miscompares++;
                $display("FAIL %s resp_payload h%0d: got res=%h cyc=%0d err=%b want res=%h cyc=%0d err=%b",
                         name, h, rsp_result_o, rsp_cycles_o, rsp_err_o, exp_res, exp_cyc, exp_err);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0; valid_i = 1'b0; req_valid = 1'b0;
        vectors++;
        if ({busy_o, req_ready_o, rsp_valid_o, mult_en_o, div_en_o} !== 5'b01000) begin
            miscompares++;
            $display("FAIL %s idle_status: got %b want 01000", name,
                     {busy_o, req_ready_o, rsp_valid_o, mult_en_o, div_en_o});
        end
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if ({req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o, signed_mode_o,
             op_a_o, op_b_o, data_ind_timing_o, multdiv_ready_id_o, rsp_valid_o, rsp_result_o,
             rsp_cycles_o, rsp_err_o, busy_o} !== '0) begin
            miscompares++;
            $display("FAIL %s outputs_zero: got %h want 0", name,
                     {req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o, signed_mode_o,
                      op_a_o, op_b_o, data_ind_timing_o, multdiv_ready_id_o, rsp_valid_o, rsp_result_o,
                      rsp_cycles_o, rsp_err_o, busy_o});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mull();
        do_op(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b0, 5, 0, "mull_7x6");
    endtask

    task automatic test_div_by_zero();
        do_op(MD_OP_DIV, 2'b00, 32'd100, 32'd0, 1'b0, DIVC, 0, "div_by_zero");
    endtask

    task automatic test_rem_signed();
        do_op(MD_OP_REM, 2'b11, 32'hFFFF_FFF8, 32'd3, 1'b0, 20, 1, "rem_signed");
    endtask

    // Long response stall followed immediately by the next request
    task automatic test_back_to_back();
        do_op(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b0, 3, 10, "backpressure");
        do_op(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 1, 0, "back_to_back");
    endtask

    task automatic test_timeout();
        do_op(MD_OP_MULL, 2'b00, 32'd1234, 32'd5678, 1'b0, 0, 2, "timeout");
        do_op(MD_OP_DIV, 2'b00, 32'd1000, 32'd7, 1'b0, TO, 0, "valid_at_limit");
    endtask

    task automatic test_dit();
        do_op(MD_OP_MULH, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b1, MULC, 0, "dit_mulh_0_ff");
        do_op(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'h0, 1'b1, MULC, 0, "dit_mulh_ff_0");
`ifndef IBEX_MULTDIV_DIT_CHECK_EN
        // Without the check a wrong latency is not an error
        do_op(MD_OP_MULH, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b1, 10, 0, "dit_unchecked");
`endif
    endtask

    task automatic test_reset_mid_busy();
        req_valid = 1'b1; req_op = MD_OP_DIV; req_sm = 2'b00; req_a = 32'd77; req_b = 32'd3; dit_i = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_busy");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid_o, busy_o, div_en_o} !== 3'b000) begin
                miscompares++;
                $display("FAIL post_reset_quiet c%0d: got %b want 000", i, {rsp_valid_o, busy_o, div_en_o});
            end
        end
    endtask

    task automatic test_random();
        md_op_e      op;
        logic [1:0]  sm;
        logic [31:0] a, b;
        logic        dit;
        int          lat;
        bit          is_mul;
        for (int n = 0; n < 20; n++) begin
            op     = md_op_e'($urandom_range(0, 3));
            is_mul = (op == MD_OP_MULL) || (op == MD_OP_MULH);
            sm     = is_mul ? 2'($urandom) : ($urandom_range(0, 1) ? 2'b11 : 2'b00);
            a      = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
            b      = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            dit    = 1'($urandom);
            if (dit)                            lat = is_mul ? MULC : DIVC;
            else if ($urandom_range(0, 9) == 0) lat = 0;
            else                                lat = $urandom_range(1, 40);
            do_op(op, sm, a, b, dit, lat, $urandom_range(0, 3), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        req_valid = 1'b0; req_op = MD_OP_MULL; req_sm = 2'b00; req_a = '0; req_b = '0;
        dit_i = 1'b0; valid_i = 1'b0; result_i = '0; rsp_ready = 1'b0;
        test_reset();
        test_mull();
        test_div_by_zero();
        test_rem_signed();
        test_back_to_back();
        test_timeout();
        test_dit();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time bound");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/ibex_multdiv_issuer.md
Name: ibex_multdiv_issuer

Overview:
- Initiator-side sequencer for the Ibex multiply/divide unit; sits where the ID stage would normally drive `ibex_multdiv_*`.
- Accepts one operation per request handshake and drives enables, selects, operator and operands, holding them stable until the unit raises valid.
- Acknowledges completion with a one-cycle multdiv_ready_id, buffers the result and the measured latency, and returns them on a response handshake.
- Used in standalone multdiv benches and timing characterisation.

Parameters:
- CntW, 6: latency counter width; counter saturates at 2^CntW-1.
- TimeoutCycles, 48: cycles in BUSY without valid before abort.
- MulCycles, 34: expected MUL latency (cycles) in data-independent-timing mode.
- DivCycles, 37: expected DIV/REM latency in data-independent-timing mode.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  md_op_e  operator
- req_signed_mode_i  in  2  signedness {b,a}
- req_op_a_i  in  32  operand A
- req_op_b_i  in  32  operand B
- data_ind_timing_i  in  1  data-independent timing mode; forwarded
- mult_en_o  out  1  multiplier dynamic enable
- div_en_o  out  1  divider dynamic enable
- mult_sel_o  out  1  multiplier mux select
- div_sel_o  out  1  divider mux select
- operator_o  out  md_op_e  operator to unit
- signed_mode_o  out  2  signedness to unit
- op_a_o  out  32  operand A to unit
- op_b_o  out  32  operand B to unit
- data_ind_timing_o  out  1  registered copy of data_ind_timing_i
- multdiv_ready_id_o  out  1  completion acknowledge
- valid_i  in  1  unit result valid
- result_i  in  32  unit result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_result_o  out  32  buffered result
- rsp_cycles_o  out  CntW  measured latency
- rsp_err_o  out  1  timeout abort (bit 0) or timing mismatch
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: every output is 0, operator_o = MD_OP_MULL, state = IDLE, counter = 0.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o: latch operator, signedness, operands and data_ind_timing into registers; go to BUSY; counter = 0.
- BUSY:
  - Registered outputs drive the unit.
  - MULL/MULH: mult_sel_o = mult_en_o = 1. DIV/REM: div_sel_o = div_en_o = 1. Never both.
  - Counter increments every BUSY cycle, including the cycle valid_i is seen. The first BUSY cycle counts as 1.
  - On valid_i:
    - multdiv_ready_id_o = 1 combinationally in that same cycle.
    - Capture result_i and the count; drop enables next cycle; go to RESP.
  - valid_i in IDLE or RESP is ignored, and multdiv_ready_id_o stays 0.
  - If the count reaches TimeoutCycles without valid_i:
    - Pulse multdiv_ready_id_o for 1 cycle to release the unit.
    - rsp_err_o = 1, rsp_result_o = 0; go to RESP.
- RESP:
  - rsp_valid_o = 1; outputs held stable until rsp_ready_i.
  - On handshake, go to IDLE.
  - req_ready_o = 0. No new request is accepted in the handshake cycle; minimum issue interval is latency + 2 cycles.
- Widths: the counter saturates and does not wrap; rsp_cycles_o is the saturated value.
- Reset mid-operation: asynchronous return to IDLE. Enables drop immediately, and no response is produced.
- Operands and operator are never changed while BUSY. Changes on req_* during BUSY/RESP are ignored.

Optional Feature:
- Macro IBEX_MULTDIV_DIT_CHECK_EN.
- Defined: when the latched data_ind_timing = 1, compare the captured count against MulCycles (MULL/MULH) or DivCycles (DIV/REM). On mismatch, set rsp_err_o = 1 in RESP while keeping the result. Also add an assertion via `prim_assert` that the count equals the expected value when valid_i fires.
- Undefined: no comparison; rsp_err_o reflects timeout only.

Decomposition:
- ibex_pkg: reuse md_op_e.
- Add to ibex_pkg: a multdiv_issue_state_e enum {MDI_IDLE, MDI_BUSY, MDI_RESP}, and the expected-latency constants used as parameter defaults.
- One sub-module is natural: ibex_multdiv_lat_counter (saturating counter with clear/enable and timeout compare).

Test Plan:
- MULL, a = 7, b = 6, signed_mode = 00 → rsp_result = 42; mult_en high only in BUSY; multdiv_ready_id a 1-cycle pulse coincident with valid_i.
- DIV, a = 100, b = 0 → rsp_result = 0xFFFFFFFF; div_en only, mult_en never asserted.
- REM signed, a = 0xFFFFFFF8 (-8), b = 3, signed_mode = 11 → rsp_result = 0xFFFFFFFE; rsp_err = 0.
- Backpressure: hold rsp_ready_i = 0 for 10 cycles after valid → rsp_valid, result and cycles stable; req_ready = 0 throughout; new request is accepted only after the handshake.
- Stub unit never asserts valid_i → after 48 BUSY cycles, rsp_err = 1, result = 0, rsp_cycles = 48, one ready pulse.
- data_ind_timing = 1, MULH with operands 0 and 0xFFFFFFFF, macro defined → both give rsp_cycles = MulCycles and rsp_err = 0. Stub valid forced at cycle 10 → rsp_err = 1.
- Reset asserted mid-BUSY → all outputs 0 asynchronously; no rsp_valid after release.
